// File: rtl/ahb_master_arbiter_2m.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ahb_master_arbiter_2m
// Purpose  : Shares one AHB-lite system bus between master 0 (CPU) and
//            master 1 (DMA/debug). Each master gets a private AHB-lite port.
//            A contended address phase is parked in a per-master holding
//            register and issued later; an uncontended master goes straight
//            through with no added latency. Every issued transfer is NONSEQ.
// Ports    : HCLK, HRESET (async, active-high)
//            Master side : HADDR/HTRANS/HWRITE/HSIZE/HWDATA_Mx in,
//                          HREADY/HRDATA/HRESP_Mx out
//            Bus side    : HADDR/HTRANS/HWRITE/HSIZE/HWDATA out,
//                          HREADY/HRDATA/HRESP in
//            GRANT       : one-hot address-phase owner, 00 when idle
// Params   : ARB_MODE  0 = fixed priority (M0 wins), 1 = round-robin
// Revision : 1.0  initial release
// ============================================================================
module ahb_master_arbiter_2m #(
    parameter bit ARB_MODE = 1'b0
) (
    input  logic        HCLK,
    input  logic        HRESET,
    // master 0
    input  logic [31:0] HADDR_M0,
    input  logic [1:0]  HTRANS_M0,
    input  logic        HWRITE_M0,
    input  logic [2:0]  HSIZE_M0,
    input  logic [31:0] HWDATA_M0,
    output logic        HREADY_M0,
    output logic [31:0] HRDATA_M0,
    output logic        HRESP_M0,
    // master 1
    input  logic [31:0] HADDR_M1,
    input  logic [1:0]  HTRANS_M1,
    input  logic        HWRITE_M1,
    input  logic [2:0]  HSIZE_M1,
    input  logic [31:0] HWDATA_M1,
    output logic        HREADY_M1,
    output logic [31:0] HRDATA_M1,
    output logic        HRESP_M1,
    // shared bus
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [31:0] HWDATA,
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP,
    output logic [1:0]  GRANT
);

    // per-master pending flag and holding registers
    logic        pend_0;
    logic        pend_1;
    logic [31:0] hold_addr_0;
    logic [31:0] hold_addr_1;
    logic        hold_write_0;
    logic        hold_write_1;
    logic [2:0]  hold_size_0;
    logic [2:0]  hold_size_1;

    // shared data-phase tracking and round-robin history
    logic        dph_valid;
    logic        dph_owner;
    logic        rr_last;

    logic        acc_0;
    logic        acc_1;
    logic        req_0;
    logic        req_1;
    logic        win_valid;
    logic        winner;

    // Only NONSEQ/SEQ (bit 1) matter; BUSY/IDLE are treated the same.
    logic        unused_trans_lsb;
    assign unused_trans_lsb = HTRANS_M0[0] ^ HTRANS_M1[0];

    // ------------------------------------------------------------------
    // Per-master ready: the data-phase owner follows the bus, a parked
    // master is stalled, anyone else is free to start a transfer.
    // ------------------------------------------------------------------
    always_comb begin
        HREADY_M0 = 1'b1;
        if (dph_valid && !dph_owner) begin
            HREADY_M0 = HREADY;
        end else if (pend_0) begin
            HREADY_M0 = 1'b0;
        end
    end

    always_comb begin
        HREADY_M1 = 1'b1;
        if (dph_valid && dph_owner) begin
            HREADY_M1 = HREADY;
        end else if (pend_1) begin
            HREADY_M1 = 1'b0;
        end
    end

    assign HRESP_M0  = dph_valid & ~dph_owner & HRESP;
    assign HRESP_M1  = dph_valid &  dph_owner & HRESP;
    assign HRDATA_M0 = HRDATA;
    assign HRDATA_M1 = HRDATA;

    // A pending master holds its own HWDATA (its HREADY is low), so the
    // write data can be muxed straight from the data-phase owner.
    assign HWDATA = dph_owner ? HWDATA_M1 : HWDATA_M0;

    // A master sees its address accepted whenever it requests while its
    // own ready is high; that is the moment it moves on.
    assign acc_0 = HTRANS_M0[1] & HREADY_M0;
    assign acc_1 = HTRANS_M1[1] & HREADY_M1;
    assign req_0 = pend_0 | acc_0;
    assign req_1 = pend_1 | acc_1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        win_valid = req_0 | req_1;
        winner    = 1'b0;
        if (req_0 && req_1) begin
            winner = ARB_MODE ? ~rr_last : 1'b0;
        end else begin
            winner = req_1 & ~req_0;
        end
    end

    // ------------------------------------------------------------------
    // Shared-bus address phase
    // ------------------------------------------------------------------
    always_comb begin
        HTRANS = 2'b00;
        HADDR  = HADDR_M0;
        HWRITE = HWRITE_M0;
        HSIZE  = HSIZE_M0;
        GRANT  = 2'b00;
        if (win_valid) begin
            // bursts are flattened: every beat goes out as NONSEQ
            HTRANS = 2'b10;
            if (winner) begin
                GRANT = 2'b10;
                if (pend_1) begin
                    HADDR  = hold_addr_1;
                    HWRITE = hold_write_1;
                    HSIZE  = hold_size_1;
                end else begin
                    HADDR  = HADDR_M1;
                    HWRITE = HWRITE_M1;
                    HSIZE  = HSIZE_M1;
                end
            end else begin
                GRANT = 2'b01;
                if (pend_0) begin
                    HADDR  = hold_addr_0;
                    HWRITE = hold_write_0;
                    HSIZE  = hold_size_0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State update; nothing moves while the bus is stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_0       <= 1'b0;
            pend_1       <= 1'b0;
            hold_addr_0  <= 32'h0;
            hold_addr_1  <= 32'h0;
            hold_write_0 <= 1'b0;
            hold_write_1 <= 1'b0;
            hold_size_0  <= 3'b000;
            hold_size_1  <= 3'b000;
            dph_valid    <= 1'b0;
            dph_owner    <= 1'b0;
            rr_last      <= 1'b1;   // M0 gets the first round-robin tie
        end else if (HREADY) begin
            if (win_valid) begin
                dph_valid <= 1'b1;
                dph_owner <= winner;
                rr_last   <= winner;
                if (winner) begin
                    pend_1 <= 1'b0;
                    if (acc_0) begin
                        pend_0       <= 1'b1;
                        hold_addr_0  <= HADDR_M0;
                        hold_write_0 <= HWRITE_M0;
                        hold_size_0  <= HSIZE_M0;
                    end
                end else begin
                    pend_0 <= 1'b0;
                    if (acc_1) begin
                        pend_1       <= 1'b1;
                        hold_addr_1  <= HADDR_M1;
                        hold_write_1 <= HWRITE_M1;
                        hold_size_1  <= HSIZE_M1;
                    end
                end
            end else begin
                dph_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_master_arbiter_2m.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ahb_master_arbiter_2m
// Purpose  : Self-checking bench. Instance 0 is fixed priority, instance 1
//            is round-robin. Directed vector table, hand-written corner
//            sequences and a randomized run against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_master_arbiter_2m;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic [1:0][31:0] haddr_m0, haddr_m1, hwdata_m0, hwdata_m1;
    logic [1:0][1:0]  htrans_m0, htrans_m1;
    logic [1:0]       hwrite_m0, hwrite_m1;
    logic [1:0][2:0]  hsize_m0, hsize_m1;
    logic [1:0]       hready_m0, hready_m1, hresp_m0, hresp_m1;
    logic [1:0][31:0] hrdata_m0, hrdata_m1, haddr, hwdata;
    logic [1:0][1:0]  htrans, grant;
    logic [1:0]       hwrite;
    logic [1:0][2:0]  hsize;
    logic             hready, hresp;
    logic [31:0]      hrdata;

    int checks = 0;
    int errors = 0;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        ahb_master_arbiter_2m #(.ARB_MODE(k == 1)) u_dut (
            .HCLK(clk), .HRESET(rst),
            .HADDR_M0(haddr_m0[k]), .HTRANS_M0(htrans_m0[k]), .HWRITE_M0(hwrite_m0[k]),
            .HSIZE_M0(hsize_m0[k]), .HWDATA_M0(hwdata_m0[k]), .HREADY_M0(hready_m0[k]),
            .HRDATA_M0(hrdata_m0[k]), .HRESP_M0(hresp_m0[k]),
            .HADDR_M1(haddr_m1[k]), .HTRANS_M1(htrans_m1[k]), .HWRITE_M1(hwrite_m1[k]),
            .HSIZE_M1(hsize_m1[k]), .HWDATA_M1(hwdata_m1[k]), .HREADY_M1(hready_m1[k]),
            .HRDATA_M1(hrdata_m1[k]), .HRESP_M1(hresp_m1[k]),
            .HADDR(haddr[k]), .HTRANS(htrans[k]), .HWRITE(hwrite[k]), .HSIZE(hsize[k]),
            .HWDATA(hwdata[k]), .HREADY(hready), .HRDATA(hrdata), .HRESP(hresp),
            .GRANT(grant[k])
        );
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_m(input int k, input int m, input logic [1:0] t, input logic [31:0] a,
                           input logic w, input logic [31:0] d, input logic [2:0] s);
        if (m == 0) begin
            htrans_m0[k] = t; haddr_m0[k] = a; hwrite_m0[k] = w; hwdata_m0[k] = d; hsize_m0[k] = s;
        end else begin
            htrans_m1[k] = t; haddr_m1[k] = a; hwrite_m1[k] = w; hwdata_m1[k] = d; hsize_m1[k] = s;
        end
    endtask

    task automatic idle(input int k);
        drive_m(k, 0, 2'b00, 32'h0, 1'b0, 32'h0, 3'b010);
        drive_m(k, 1, 2'b00, 32'h0, 1'b0, 32'h0, 3'b010);
    endtask

    // ------------------------------------------------------------------
    // Reference model: each master has at most one parked request; the
    // bus tracks which master (if any) owns the data phase.
    // ------------------------------------------------------------------
    typedef struct {
        bit          valid;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
    } held_t;

    typedef struct packed {
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [1:0]  grant;
        logic        r0, r1, p0, p1;
    } exp_t;

    held_t held [2][2];
    int    owner [2];       // -1: no data phase
    int    last [2];
    int    m_win [2];
    bit    m_live [2][2];
    logic  rdy_s [2][2];

    function automatic logic [31:0] l_addr(int k, int m);  return m ? haddr_m1[k]  : haddr_m0[k];  endfunction
    function automatic logic        l_write(int k, int m); return m ? hwrite_m1[k] : hwrite_m0[k]; endfunction
    function automatic logic [2:0]  l_size(int k, int m);  return m ? hsize_m1[k]  : hsize_m0[k];  endfunction
    function automatic logic [1:0]  l_trans(int k, int m); return m ? htrans_m1[k] : htrans_m0[k]; endfunction

    task automatic model_reset(input int k);
        for (int m = 0; m < 2; m++) held[k][m].valid = 1'b0;
        owner[k] = -1;
        last[k]  = 1;
    endtask

    function automatic exp_t model_eval(input int k);
        exp_t e;
        bit   rdy [2];
        bit   want [2];
        int   w;
        for (int m = 0; m < 2; m++) begin
            rdy[m]       = (owner[k] == m) ? hready : !held[k][m].valid;
            m_live[k][m] = l_trans(k, m)[1] && rdy[m];
            want[m]      = held[k][m].valid || m_live[k][m];
        end
        if (want[0] && want[1]) w = (k == 0) ? 0 : 1 - last[k];
        else if (want[0])       w = 0;
        else if (want[1])       w = 1;
        else                    w = -1;
        m_win[k] = w;
        if (w < 0) begin
            e.trans = 2'b00; e.grant = 2'b00;
            e.addr = l_addr(k, 0); e.write = l_write(k, 0); e.size = l_size(k, 0);
        end else begin
            e.trans = 2'b10; e.grant = (w == 0) ? 2'b01 : 2'b10;
            if (held[k][w].valid) begin
                e.addr = held[k][w].addr; e.write = held[k][w].write; e.size = held[k][w].size;
            end else begin
                e.addr = l_addr(k, w); e.write = l_write(k, w); e.size = l_size(k, w);
            end
        end
        e.r0 = rdy[0];
        e.r1 = rdy[1];
        e.p0 = (owner[k] == 0) ? hresp : 1'b0;
        e.p1 = (owner[k] == 1) ? hresp : 1'b0;
        return e;
    endfunction

    task automatic model_edge(input int k);
        int w;
        int l;
        if (hready) begin
            w = m_win[k];
            if (w >= 0) begin
                l = 1 - w;
                owner[k] = w;
                last[k]  = w;
                held[k][w].valid = 1'b0;
                if (m_live[k][l]) begin
                    held[k][l].valid = 1'b1;
                    held[k][l].addr  = l_addr(k, l);
                    held[k][l].write = l_write(k, l);
                    held[k][l].size  = l_size(k, l);
                end
            end else begin
                owner[k] = -1;
            end
        end
    endtask

    task automatic check_model(input int k);
        exp_t e;
        string p;
        p = $sformatf("rand_i%0d", k);
        e = model_eval(k);
        check({p, "_trans"}, htrans[k], e.trans);
        check({p, "_addr"},  haddr[k],  e.addr);
        check({p, "_write"}, hwrite[k], e.write);
        check({p, "_size"},  hsize[k],  e.size);
        check({p, "_grant"}, grant[k],  e.grant);
        check({p, "_rdy0"},  hready_m0[k], e.r0);
        check({p, "_rdy1"},  hready_m1[k], e.r1);
        check({p, "_resp0"}, hresp_m0[k],  e.p0);
        check({p, "_resp1"}, hresp_m1[k],  e.p1);
        check({p, "_rdata"}, hrdata_m0[k] ^ hrdata_m1[k] ^ hrdata, hrdata);
        if (owner[k] >= 0)
            check({p, "_wdata"}, hwdata[k], (owner[k] == 1) ? hwdata_m1[k] : hwdata_m0[k]);
        rdy_s[k][0] = hready_m0[k];
        rdy_s[k][1] = hready_m1[k];
        model_edge(k);
    endtask

    // ------------------------------------------------------------------
    // Directed vector table for the fixed-priority instance
    // ------------------------------------------------------------------
    typedef struct {
        logic [1:0] t0; logic [31:0] a0; logic w0; logic [31:0] d0;
        logic [1:0] t1; logic [31:0] a1; logic w1;
        logic hr; logic rs;
        logic [1:0] e_trans; logic [31:0] e_addr; logic e_write;
        logic e_r0; logic e_r1; logic [1:0] e_gnt; logic e_p0; logic e_p1;
        logic e_cw; logic [31:0] e_wd;
    } vec_t;

    vec_t vt [15];

    function automatic logic [31:0] rr_addr(int m, int i);
        return 32'h1000_0000 + 32'(m) * 32'h1000_0000 + 32'(i) * 4;
    endfunction

    initial begin
        int          ridx [2];
        bit          pres [2];
        logic        rrdy [2];
        int          sent;
        int          rsel;
        logic [1:0]  rt;

        // single read with 2 wait states
        vt[0]  = '{2'b10, 32'h2000_0000, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h2000_0000, 1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[1]  = '{2'b00, 32'h2000_0000, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h2000_0000, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[2]  = '{2'b00, 32'h2000_0000, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h2000_0000, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[3]  = '{2'b00, 32'h2000_0000, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h2000_0000, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        // simultaneous write M0 / read M1
        vt[4]  = '{2'b10, 32'h2000_0004, 1'b1, 32'h0, 2'b10, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 2'b10, 32'h2000_0004, 1'b1, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[5]  = '{2'b00, 32'h0, 1'b0, 32'hDEAD_BEEF, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 2'b10, 32'h4000_0000, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF};
        vt[6]  = '{2'b00, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        // two-cycle error on M1
        vt[7]  = '{2'b00, 32'h0, 1'b0, 32'h0, 2'b10, 32'h4000_0010, 1'b0, 1'b1, 1'b0, 2'b10, 32'h4000_0010, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[8]  = '{2'b00, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b0, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[9]  = '{2'b00, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0};
        vt[10] = '{2'b00, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        // SEQ burst from M1 flattened to NONSEQ
        vt[11] = '{2'b00, 32'h0, 1'b0, 32'h0, 2'b10, 32'h4000_0020, 1'b0, 1'b1, 1'b0, 2'b10, 32'h4000_0020, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[12] = '{2'b00, 32'h0, 1'b0, 32'h0, 2'b11, 32'h4000_0024, 1'b0, 1'b1, 1'b0, 2'b10, 32'h4000_0024, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[13] = '{2'b00, 32'h0, 1'b0, 32'h0, 2'b11, 32'h4000_0028, 1'b0, 1'b1, 1'b0, 2'b10, 32'h4000_0028, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 32'h0};
        vt[14] = '{2'b00, 32'h0, 1'b0, 32'h0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b0, 2'b00, 32'h0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};

        // ---------------- reset state ----------------
        rst = 1'b1; hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
        idle(0); idle(1);
        #12;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset_i%0d_trans", k), htrans[k], 2'b00);
            check($sformatf("reset_i%0d_grant", k), grant[k], 2'b00);
            check($sformatf("reset_i%0d_rdy", k), {hready_m0[k], hready_m1[k]}, 2'b11);
            check($sformatf("reset_i%0d_resp", k), {hresp_m0[k], hresp_m1[k]}, 2'b00);
        end
        @(negedge clk);
        rst = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            drive_m(0, 0, vt[i].t0, vt[i].a0, vt[i].w0, vt[i].d0, 3'b010);
            drive_m(0, 1, vt[i].t1, vt[i].a1, vt[i].w1, 32'h0, 3'b010);
            hready = vt[i].hr;
            hresp  = vt[i].rs;
            @(negedge clk);
            check($sformatf("vec%0d_trans", i), htrans[0], vt[i].e_trans);
            check($sformatf("vec%0d_addr", i),  haddr[0],  vt[i].e_addr);
            check($sformatf("vec%0d_grant", i), grant[0],  vt[i].e_gnt);
            check($sformatf("vec%0d_rdy0", i),  hready_m0[0], vt[i].e_r0);
            check($sformatf("vec%0d_rdy1", i),  hready_m1[0], vt[i].e_r1);
            check($sformatf("vec%0d_resp0", i), hresp_m0[0],  vt[i].e_p0);
            check($sformatf("vec%0d_resp1", i), hresp_m1[0],  vt[i].e_p1);
            if (vt[i].e_trans == 2'b10) check($sformatf("vec%0d_write", i), hwrite[0], vt[i].e_write);
            if (vt[i].e_cw) check($sformatf("vec%0d_wdata", i), hwdata[0], vt[i].e_wd);
        end
        @(posedge clk); #1;
        idle(0); hready = 1'b1; hresp = 1'b0;

        // ---------------- round-robin streaming ----------------
        for (int m = 0; m < 2; m++) begin ridx[m] = 0; pres[m] = 1'b0; rrdy[m] = 1'b1; end
        sent = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            @(posedge clk); #1;
            for (int m = 0; m < 2; m++) begin
                if (pres[m] && rrdy[m]) ridx[m]++;
                if (ridx[m] < 4) begin
                    drive_m(1, m, 2'b10, rr_addr(m, ridx[m]), 1'b0, 32'h0, 3'b010);
                    pres[m] = 1'b1;
                end else begin
                    drive_m(1, m, 2'b00, 32'h0, 1'b0, 32'h0, 3'b010);
                    pres[m] = 1'b0;
                end
            end
            @(negedge clk);
            rrdy[0] = hready_m0[1];
            rrdy[1] = hready_m1[1];
            if (htrans[1] == 2'b10) begin
                check($sformatf("rr%0d_addr", sent), haddr[1], rr_addr(sent % 2, sent / 2));
                check($sformatf("rr%0d_grant", sent), grant[1], (sent % 2) ? 2'b10 : 2'b01);
                sent++;
            end
        end
        check("rr_count", sent, 8);
        @(posedge clk); #1; idle(1);
        @(posedge clk); #1;

        // ---------------- reset while M1 pending (RR instance) ----------------
        drive_m(1, 0, 2'b10, 32'h5000_0000, 1'b0, 32'h0, 3'b010);
        drive_m(1, 1, 2'b10, 32'h6000_0000, 1'b0, 32'h0, 3'b010);
        @(negedge clk);
        check("pre_rst_grant", grant[1], 2'b01);
        @(posedge clk); #1; idle(1);
        @(negedge clk);
        check("pre_rst_rdy1", hready_m1[1], 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_async_trans", htrans[1], 2'b00);
        check("rst_async_grant", grant[1], 2'b00);
        check("rst_async_rdy", {hready_m0[1], hready_m1[1]}, 2'b11);
        check("rst_async_resp", {hresp_m0[1], hresp_m1[1]}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        drive_m(1, 0, 2'b10, 32'h5000_0010, 1'b0, 32'h0, 3'b010);
        drive_m(1, 1, 2'b10, 32'h6000_0010, 1'b0, 32'h0, 3'b010);
        @(negedge clk);
        check("post_rst_grant", grant[1], 2'b01);
        check("post_rst_addr", haddr[1], 32'h5000_0010);
        @(posedge clk); #1; idle(1);

        // ---------------- randomized run against the model ----------------
        rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            rdy_s[k][0] = 1'b1;
            rdy_s[k][1] = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                for (int m = 0; m < 2; m++) begin
                    if (rdy_s[k][m]) begin
                        rsel = $urandom_range(0, 3);
                        rt   = (rsel == 0) ? 2'b00 : ((rsel == 3) ? 2'b11 : 2'b10);
                        drive_m(k, m, rt, $urandom, 1'($urandom), $urandom, 3'($urandom_range(0, 2)));
                    end
                end
            end
            hready = ($urandom_range(0, 3) != 0);
            hresp  = ($urandom_range(0, 7) == 0);
            hrdata = $urandom;
            @(negedge clk);
            check_model(0);
            check_model(1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
